// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory main-memory model.
//   - default geometry (line width, depth, address width) and access latency
//   - OFFSET_BITS: byte-offset bits inside one line (32-byte lines)
//   - state_e: access FSM states
package data_memory_pkg;

  localparam int MEM_LINE_W  = 256;
  localparam int MEM_DEPTH   = 512;
  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_LATENCY = 10;
  localparam int OFFSET_BITS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory.sv
// data_memory: block-granular main memory behind the write-back data cache.
// One cache line per access, fixed LATENCY-edge latency, enable/ack handshake.
//   clk_i    : clock, all state changes on the rising edge
//   rst_i    : asynchronous active-low reset (does not touch the array)
//   addr_i   : byte address; line index = addr_i[13:5], other bits ignored
//   data_i   : line to write, sampled on the ack edge
//   enable_i : request valid, accepted only in IDLE
//   write_i  : 1 = write, 0 = read, sampled on the ack edge
//   ack_o    : one-cycle completion strobe
//   data_o   : line at addr_i, combinational (valid during ack of a read)
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LINE_W  = MEM_LINE_W,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  // Array name is relied on by the bench for hierarchical preload/flush.
  logic [LINE_W-1:0] memory [0:DEPTH-1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx;

  // Slicing the index out of the address gives the modulo-DEPTH wrap.
  assign idx = addr_i[OFFSET_BITS +: IDX_W];

  // Offset and upper address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

  // Combinational from state so reset drops it immediately.
  assign ack_o  = (state_q == WAIT) && (count_q == CNT_LAST);
  assign data_o = memory[idx];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable_i) state_d = WAIT;
      end
      WAIT: begin
        // enable_i is not looked at here: a started access always completes.
        if (ack_o) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // No reset on the array: preloaded contents must survive reset.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) memory[idx] <= data_i;
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int tests  = 0;
  int failed = 0;

  // Reference model: plain array of lines, indexed by (addr / 32) mod 512.
  logic [255:0] ref_mem [512];

  data_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
      $error("%s mismatch", tag);
    end
  endtask

  // One isolated access; enable_i drops right after acceptance.
  // lat = cycles from acceptance to first ack-high cycle (0 on timeout).
  task automatic access(input logic [31:0] a, input logic [255:0] d, input logic wr,
                        output int lat, output logic [255:0] rd, output logic ack_after);
    @(negedge clk_i);
    addr_i = a; data_i = d; write_i = wr; enable_i = 1'b1;
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    lat = 0;
    rd  = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (ack_o) begin
        lat = n;
        rd  = data_o;
        break;
      end
    end
    @(negedge clk_i);
    ack_after = ack_o;
  endtask

  initial begin
    int           lat, t1, t2;
    logic [255:0] rd, d;
    logic [31:0]  a;
    logic         ack_after, seen, wr;

    rst_i = 1'b0; addr_i = '0; data_i = '0; enable_i = 1'b0; write_i = 1'b0;
    ref_mem[0] = 256'h5;
    for (int i = 1; i < 8; i++) ref_mem[i] = rnd_line();
    for (int i = 0; i < 8; i++) dut.memory[i] = ref_mem[i];

    // Reset hold and quiet release
    repeat (3) @(negedge clk_i);
    chk("ack_in_reset", 256'(ack_o), 256'(0));
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (ack_o) seen = 1'b1;
    end
    chk("idle_no_ack", 256'(seen), 256'(0));
    chk("preload_kept", dut.memory[0], ref_mem[0]);

    // Basic read of line 0
    access(32'h0, '0, 1'b0, lat, rd, ack_after);
    chk("rd0_latency", 256'(lat), 256'(LAT));
    chk("rd0_data", rd, ref_mem[0]);
    chk("rd0_ack_width", 256'(ack_after), 256'(0));

    // Write line 1, then read it back through several aliases
    access(32'h20, 256'hABCD, 1'b1, lat, rd, ack_after);
    ref_mem[line_of(32'h20)] = 256'hABCD;
    chk("wr1_latency", 256'(lat), 256'(LAT));
    chk("wr1_array", dut.memory[1], ref_mem[1]);
    access(32'h20, '0, 1'b0, lat, rd, ack_after);
    chk("rd1_data", rd, ref_mem[1]);
    access(32'h3F, '0, 1'b0, lat, rd, ack_after);
    chk("rd_offset_3f", rd, ref_mem[line_of(32'h3F)]);
    access(32'h4000, '0, 1'b0, lat, rd, ack_after);
    chk("rd_wrap_4000", rd, ref_mem[line_of(32'h4000)]);

    // Back-to-back with enable held: write line 3, then read it
    d = rnd_line();
    @(negedge clk_i);
    addr_i = 32'h60; data_i = d; write_i = 1'b1; enable_i = 1'b1;
    t1 = 0; t2 = 0; rd = 'x;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_i);
      if (ack_o) begin
        if (t1 == 0) begin
          t1 = n;
          ref_mem[3] = d;
          @(posedge clk_i);
          #1 write_i = 1'b0; data_i = '0;
        end else begin
          t2 = n;
          rd = data_o;
          enable_i = 1'b0;
          break;
        end
      end
    end
    chk("b2b_first_lat", 256'(t1), 256'(LAT));
    chk("b2b_spacing", 256'(t2 - t1), 256'(LAT + 1));
    chk("b2b_read_data", rd, ref_mem[3]);
    @(negedge clk_i);

    // Randomized accesses over lines 0..7 with random offset/upper bits
    for (int it = 0; it < 24; it++) begin
      a  = {$urandom_range(0, 262143) & 32'h3FFFF, 9'($urandom_range(0, 7)), 5'($urandom)};
      wr = 1'($urandom);
      d  = rnd_line();
      access(a, d, wr, lat, rd, ack_after);
      chk($sformatf("rnd%0d_latency", it), 256'(lat), 256'(LAT));
      chk($sformatf("rnd%0d_ack_width", it), 256'(ack_after), 256'(0));
      if (wr) begin
        ref_mem[line_of(a)] = d;
        chk($sformatf("rnd%0d_wr_array", it), dut.memory[line_of(a)], ref_mem[line_of(a)]);
      end else begin
        chk($sformatf("rnd%0d_rd_data", it), rd, ref_mem[line_of(a)]);
      end
    end

    // Reset mid-WAIT on a write to line 2: abandoned, line untouched
    @(negedge clk_i);
    addr_i = 32'h40; data_i = ~ref_mem[2]; write_i = 1'b1; enable_i = 1'b1;
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("rst_ack_drop", 256'(ack_o), 256'(0));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (ack_o) seen = 1'b1;
    end
    rst_i = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      if (ack_o) seen = 1'b1;
    end
    chk("rst_no_ack", 256'(seen), 256'(0));
    chk("rst_line_kept", dut.memory[2], ref_mem[2]);
    access(32'h40, '0, 1'b0, lat, rd, ack_after);
    chk("post_rst_latency", 256'(lat), 256'(LAT));
    chk("post_rst_data", rd, ref_mem[2]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
